// File: rtl/pru_vga_scanout.sv
// ---------------------------------------------------------------------------
// pru_vga_scanout: VGA timing generator that scans a 2-bit PRU frame buffer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pru_vga_scanout #(
   parameter int          H_ACTIVE = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_ACTIVE = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33,
   parameter logic [95:0] PALETTE  = 96'h000000_FF0000_00FF00_FFFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [18:0] re_addr,
   input  logic [1:0]  rd_data,
   output logic [23:0] rgb,
   output logic        de,
   output logic        hsync_n,
   output logic        vsync_n,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [HW-1:0]  h_q, h_d;
   logic [VW-1:0]  v_q, v_d;
   logic [18:0]    addr_q, addr_d;

   logic           line_end_w, frame_end_w;
   logic           vis_w, hs_act_w, vs_act_w, fs_w;
   logic [23:0]    pal_w;

   // Stage 1 carries position-derived flags alongside the memory read.
   logic           de1_q, hs1_q, vs1_q, fs1_q;
   logic [23:0]    rgb_q;
   logic           de_q, hs_q, vs_q, fs_q;

   assign line_end_w  = (h_q == H_LAST);
   assign frame_end_w = line_end_w && (v_q == V_LAST);

   assign vis_w    = (state_q == SCAN) && (h_q < H_ACT) && (v_q < V_ACT);
   assign hs_act_w = (state_q == SCAN) && (h_q >= HS_BEG) && (h_q < HS_END);
   assign vs_act_w = (state_q == SCAN) && (v_q >= VS_BEG) && (v_q < VS_END);
   assign fs_w     = (state_q == SCAN) && (h_q == '0) && (v_q == '0);

   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      v_d     = v_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE: begin
            h_d    = '0;
            v_d    = '0;
            addr_d = '0;
            if (en) begin
               state_d = SCAN;
            end
         end
         default: begin
            h_d = line_end_w ? '0 : h_q + HW'(1);
            if (line_end_w) begin
               v_d = frame_end_w ? '0 : v_q + VW'(1);
            end
            if (frame_end_w && !en) begin
               state_d = IDLE;
            end
            // Address only advances on entry to a visible position, so it
            // holds the last fetched pixel through every blanking interval.
            if (frame_end_w) begin
               addr_d = '0;
            end else if ((h_d < H_ACT) && (v_d < V_ACT)) begin
               addr_d = addr_q + 19'd1;
            end
         end
      endcase
   end

   always_comb begin
      pal_w = '0;
      case (rd_data)
         2'd0:    pal_w = PALETTE[23:0];
         2'd1:    pal_w = PALETTE[47:24];
         2'd2:    pal_w = PALETTE[71:48];
         default: pal_w = PALETTE[95:72];
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         h_q     <= '0;
         v_q     <= '0;
         addr_q  <= '0;
         de1_q   <= 1'b0;
         hs1_q   <= 1'b1;
         vs1_q   <= 1'b1;
         fs1_q   <= 1'b0;
         rgb_q   <= '0;
         de_q    <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
         addr_q  <= addr_d;
         de1_q   <= vis_w;
         hs1_q   <= ~hs_act_w;
         vs1_q   <= ~vs_act_w;
         fs1_q   <= fs_w;
         rgb_q   <= de1_q ? pal_w : 24'h000000;
         de_q    <= de1_q;
         hs_q    <= hs1_q;
         vs_q    <= vs1_q;
         fs_q    <= fs1_q;
      end
   end

   assign re_addr     = addr_q;
   assign rgb         = rgb_q;
   assign de          = de_q;
   assign hsync_n     = hs_q;
   assign vsync_n     = vs_q;
   assign frame_start = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_pru_vga_scanout.sv
// ---------------------------------------------------------------------------
// tb_pru_vga_scanout: randomized scoreboard bench on a reduced-size raster.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pru_vga_scanout;

   localparam int HA  = 16;
   localparam int HFP = 4;
   localparam int HSY = 6;
   localparam int HBP = 4;
   localparam int VA  = 8;
   localparam int VFP = 2;
   localparam int VSY = 2;
   localparam int VBP = 3;
   localparam int HT    = HA + HFP + HSY + HBP;
   localparam int VT    = VA + VFP + VSY + VBP;
   localparam int FRAME = HT * VT;
   localparam int NPIX  = HA * VA;
   localparam logic [95:0] PAL = 96'h000000_FF0000_00FF00_FFFFFF;

   typedef struct packed {
      logic [18:0] addr;
      logic        de;
      logic [23:0] rgb;
      logic        hs;
      logic        vs;
      logic        fs;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [18:0] re_addr;
   logic [1:0]  rd_data = 2'b00;
   logic [23:0] rgb;
   logic        de, hsync_n, vsync_n, frame_start;

   logic [1:0]  mem [NPIX];
   rec_t        sb [$];
   int          n_checks = 0;
   int          n_pass   = 0;

   // Reference model state: scanning flag and linear raster position.
   logic        m_valid = 1'b0;
   logic        m_scan  = 1'b0;
   int          m_p     = 0;
   rec_t        d1, d2;

   pru_vga_scanout #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .PALETTE(PAL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .re_addr(re_addr), .rd_data(rd_data),
      .rgb(rgb), .de(de), .hsync_n(hsync_n), .vsync_n(vsync_n),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] pal(input logic [1:0] k);
      logic [95:0] p;
      p = PAL;
      return p[24*int'(k) +: 24];
   endfunction

   function automatic rec_t idle_rec();
      rec_t r;
      r    = '0;
      r.hs = 1'b1;
      r.vs = 1'b1;
      return r;
   endfunction

   function automatic rec_t scan_rec(input int p);
      rec_t r;
      int   h, v;
      logic vis;
      h   = p % HT;
      v   = p / HT;
      vis = (h < HA) && (v < VA);
      r   = '0;
      if (v >= VA)     r.addr = 19'(NPIX - 1);
      else if (h < HA) r.addr = 19'(v * HA + h);
      else             r.addr = 19'(v * HA + HA - 1);
      r.de  = vis;
      r.rgb = vis ? pal(mem[v * HA + h]) : 24'h000000;
      r.hs  = !((h >= HA + HFP) && (h < HA + HFP + HSY));
      r.vs  = !((v >= VA + VFP) && (v < VA + VFP + VSY));
      r.fs  = (p == 0);
      return r;
   endfunction

   task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Frame buffer: one clock read latency.
   initial begin
      logic [1:0] tmp;
      forever begin
         @(posedge clk);
         if ($isunknown(re_addr) || re_addr >= 19'(NPIX)) tmp = 2'b00;
         else tmp = mem[re_addr];
         #1 rd_data = tmp;
      end
   end

   // Reference model: pushes the expected output for every cycle.
   initial begin
      rec_t cur, ex;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_valid = 1'b1;
            m_scan  = 1'b0;
            m_p     = 0;
            d1      = idle_rec();
            d2      = idle_rec();
         end else if (m_valid) begin
            if (!m_scan) begin
               if (en) begin
                  m_scan = 1'b1;
                  m_p    = 0;
               end
            end else if (m_p == FRAME - 1) begin
               m_p = 0;
               if (!en) m_scan = 1'b0;
            end else begin
               m_p++;
            end
         end
         if (m_valid) begin
            cur     = m_scan ? scan_rec(m_p) : idle_rec();
            ex      = d2;
            ex.addr = cur.addr;
            sb.push_back(ex);
            d2 = d1;
            d1 = cur;
         end
      end
   end

   // Monitor: compares DUT outputs against the scoreboard head each cycle.
   initial begin
      rec_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("re_addr",     24'(re_addr),     24'(e.addr));
            chk("de",          24'(de),          24'(e.de));
            chk("rgb",         rgb,              e.rgb);
            chk("hsync_n",     24'(hsync_n),     24'(e.hs));
            chk("vsync_n",     24'(vsync_n),     24'(e.vs));
            chk("frame_start", 24'(frame_start), 24'(e.fs));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_pos(input int v, input int h);
      for (int i = 0; i < 2 * FRAME + 10; i++) begin
         @(negedge clk);
         if (m_scan && m_p == v * HT + h) return;
      end
      n_checks++;
      $display("FAIL wait_pos: never reached line %0d pixel %0d", v, h);
   endtask

   initial begin
      for (int i = 0; i < NPIX; i++) begin
         mem[i] = (i < NPIX / 2) ? 2'(i) : 2'($urandom);
      end
      rst_n = 1'b0;
      en    = 1'b0;
      repeat (3) begin
         @(negedge clk);
         en = 1'($urandom);
      end
      // Idle with en low, then start and run two full frames.
      rst_n = 1'b1;
      en    = 1'b0;
      cyc(20);
      en = 1'b1;
      cyc(2 * FRAME + 10);
      // en toggling at random: only frame-boundary samples matter.
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(negedge clk);
         en = 1'($urandom);
      end
      en = 1'b1;
      cyc(FRAME);
      // Drop en part way down a frame, then re-raise during idle.
      wait_pos(4, 0);
      en = 1'b0;
      cyc(FRAME + 40);
      en = 1'b1;
      cyc(FRAME + 20);
      // Single-clock reset mid-frame.
      wait_pos(VA / 2, HA / 2);
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      cyc(FRAME + 20);
      // Random reset pulses with random en during reset.
      for (int i = 0; i < 4; i++) begin
         cyc($urandom_range(50, 600));
         rst_n = 1'b0;
         en    = 1'($urandom);
         cyc(1 + $urandom_range(0, 2));
         rst_n = 1'b1;
         en    = 1'b1;
      end
      cyc(FRAME);
      cyc(5);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
